grey_scan: RTL and testbench

Display scanner directly downstream of the `grey` Johnson-coded decimal counter. It consumes the twelve 5-bit digit outputs, ones through hundred-billions, and takes a tear-free snapshot of them once per frame. It then scans the digits one at a time onto a single 7-segment output with digit index, thousands-separator decimal point, frame marker and sticky invalid-code flag. It feeds the chip's `io_out` pins.

---
 rtl/grey_scan.sv | 186 ++++++++++++++++++
 tb/tb_grey_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grey_scan.sv
`default_nettype none
// ============================================================================
//  Module      : grey_scan
//  Description : Multiplexed 7-segment scanner for the twelve Johnson-coded
//                digits of the grey decimal counter. Takes a tear-free
//                snapshot once per frame and shows one digit at a time for
//                DWELL cycles, with digit index, thousands-separator decimal
//                point, frame marker and sticky invalid-code flag.
//                Optional feature macro: SCAN_LZB_EN (leading-zero blanking).
//  Revision    : 1.0 - initial release
// ============================================================================
module grey_scan #(
    parameter int DWELL = 16                // cycles per digit, 2..255
) (
    input  logic        CLK,
    input  logic        RST,                // asynchronous, active low
    input  logic [59:0] DIGITS,
    input  logic        HOLD,
    input  logic        CLR_ERR,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  DIG_IDX,
    output logic        FRAME,
    output logic        ERR
);

    localparam logic [7:0] c_DWELL_LAST = 8'(DWELL - 1);
    localparam logic [3:0] c_IDX_LAST   = 4'd11;
    localparam logic [6:0] c_SEG_ERR    = 7'h79;

    // ------------------------------------------------------------------
    // Johnson decode straight to segments; bit 7 is the "valid code" flag.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_decode(input logic [4:0] code);
        case (code)
            5'b00000: f_decode = {1'b1, 7'h3F};
            5'b00001: f_decode = {1'b1, 7'h06};
            5'b00011: f_decode = {1'b1, 7'h5B};
            5'b00111: f_decode = {1'b1, 7'h4F};
            5'b01111: f_decode = {1'b1, 7'h66};
            5'b11111: f_decode = {1'b1, 7'h6D};
            5'b11110: f_decode = {1'b1, 7'h7D};
            5'b11100: f_decode = {1'b1, 7'h07};
            5'b11000: f_decode = {1'b1, 7'h7F};
            5'b10000: f_decode = {1'b1, 7'h6F};
            default:  f_decode = {1'b0, c_SEG_ERR};
        endcase
    endfunction

    // Registered state
    logic [59:0] r_snap;
    logic [7:0]  r_dwell;
    logic [3:0]  r_idx;
    logic        r_primed;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        r_frame;
    logic        r_err;

    // Next-state values
    logic [59:0] w_snap_nxt;
    logic [7:0]  w_dwell_nxt;
    logic [3:0]  w_idx_nxt;
    logic        w_frame_nxt;
    logic        w_new_digit;
    logic [4:0]  w_code;
    logic [7:0]  w_dec;
    logic        w_blank;
    logic [6:0]  w_seg_nxt;
    logic        w_dp_nxt;
    logic        w_err_nxt;

    // Scan sequencing: dwell/index counters and frame-boundary snapshot reload
    always_comb begin
        w_snap_nxt  = r_snap;
        w_dwell_nxt = r_dwell;
        w_idx_nxt   = r_idx;
        w_frame_nxt = 1'b0;
        w_new_digit = 1'b0;
        if (!r_primed) begin
            // First edge out of reset always takes a fresh snapshot
            w_snap_nxt  = DIGITS;
            w_dwell_nxt = 8'd0;
            w_idx_nxt   = 4'd0;
            w_frame_nxt = 1'b1;
            w_new_digit = 1'b1;
        end else if (r_dwell == c_DWELL_LAST) begin
            w_dwell_nxt = 8'd0;
            w_new_digit = 1'b1;
            if (r_idx == c_IDX_LAST) begin
                w_idx_nxt   = 4'd0;
                w_frame_nxt = 1'b1;
                if (!HOLD) begin
                    w_snap_nxt = DIGITS;
                end
            end else begin
                w_idx_nxt = r_idx + 4'd1;
            end
        end else begin
            w_dwell_nxt = r_dwell + 8'd1;
        end
    end

    // Select the digit shown after this edge from the post-edge snapshot
    always_comb begin
        w_code = 5'b00000;
        for (int i = 0; i < 12; i++) begin
            if (w_idx_nxt == 4'(i)) begin
                w_code = w_snap_nxt[i*5 +: 5];
            end
        end
    end

`ifdef SCAN_LZB_EN
    logic [3:0] w_msd;

    // Most significant non-zero digit of the post-edge snapshot; invalid
    // codes are non-zero raw patterns so they count automatically
    always_comb begin
        w_msd = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w_snap_nxt[i*5 +: 5] != 5'b00000) begin
                w_msd = 4'(i);
            end
        end
    end

    // Blank everything above the leading digit; index 0 can never exceed it
    always_comb begin
        w_blank = (w_idx_nxt > w_msd);
    end
`else
    // All twelve digits are always shown
    always_comb begin
        w_blank = 1'b0;
    end
`endif

    // Output pattern, decimal point and sticky error for the post-edge digit
    always_comb begin
        w_dec     = f_decode(w_code);
        w_seg_nxt = w_blank ? 7'h00 : w_dec[6:0];
        w_dp_nxt  = !w_blank && ((w_idx_nxt == 4'd3) ||
                                 (w_idx_nxt == 4'd6) ||
                                 (w_idx_nxt == 4'd9));
        // A set on this edge beats a simultaneous clear
        if (w_new_digit && !w_dec[7] && !w_blank) begin
            w_err_nxt = 1'b1;
        end else if (CLR_ERR) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // State and output registers, all updated together for coherence
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_snap   <= 60'd0;
            r_dwell  <= 8'd0;
            r_idx    <= 4'd0;
            r_primed <= 1'b0;
            r_seg    <= 7'h00;
            r_dp     <= 1'b0;
            r_frame  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_snap   <= w_snap_nxt;
            r_dwell  <= w_dwell_nxt;
            r_idx    <= w_idx_nxt;
            r_primed <= 1'b1;
            r_seg    <= w_seg_nxt;
            r_dp     <= w_dp_nxt;
            r_frame  <= w_frame_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign SEG     = r_seg;
    assign DP      = r_dp;
    assign DIG_IDX = r_idx;
    assign FRAME   = r_frame;
    assign ERR     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_grey_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grey_scan
//  Description : Self-checking bench for grey_scan with DWELL=4. Expected
//                values follow SCAN_LZB_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grey_scan;

`ifdef SCAN_LZB_EN
    localparam bit c_LZB = 1'b1;
`else
    localparam bit c_LZB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [59:0] DIGITS;
    logic        HOLD;
    logic        CLR_ERR;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  DIG_IDX;
    logic        FRAME;
    logic        ERR;

    int checks   = 0;
    int failures = 0;

    grey_scan #(.DWELL(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .DIGITS  (DIGITS),
        .HOLD    (HOLD),
        .CLR_ERR (CLR_ERR),
        .SEG     (SEG),
        .DP      (DP),
        .DIG_IDX (DIG_IDX),
        .FRAME   (FRAME),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          load;      // present new DIGITS and wait for the frame that loads them
        logic [59:0] digits;
        int          idx;
        logic [6:0]  seg;
        logic        dp;
        bit          blank;     // digit is above the leading non-zero digit
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [59:0] dig(input int i, input logic [4:0] c);
        logic [59:0] t;
        t = '0;
        t[i*5 +: 5] = c;
        return t;
    endfunction

    task automatic add(input bit load, input logic [59:0] d, input int idx,
                       input logic [6:0] seg, input logic dp, input bit blank);
        vec_t v;
        v.load = load; v.digits = d; v.idx = idx;
        v.seg = seg; v.dp = dp; v.blank = blank;
        vecs.push_back(v);
    endtask

    // Advance at least one cycle and stop on the cycle that shows FRAME
    task automatic wait_frame();
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (FRAME) return;
        end
        chk("frame_timeout", 32'd0, 32'd1);
    endtask

    // Stop on the first sampled cycle (possibly the current one) showing idx
    task automatic wait_idx(input int idx);
        for (int i = 0; i < 100; i++) begin
            if (DIG_IDX == 4'(idx)) return;
            @(negedge CLK);
        end
        chk("idx_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"},   32'(SEG),     32'h00);
        chk({tag, "_dp"},    32'(DP),      32'd0);
        chk({tag, "_idx"},   32'(DIG_IDX), 32'd0);
        chk({tag, "_frame"}, 32'(FRAME),   32'd0);
        chk({tag, "_err"},   32'(ERR),     32'd0);
    endtask

    logic [59:0] pat_b;
    logic [59:0] pat_c;
    int          cnt;

    initial begin
        RST = 1'b0; DIGITS = '0; HOLD = 1'b0; CLR_ERR = 1'b0;

        pat_b = dig(0, 5'b00111) | dig(1, 5'b10000);
        pat_c = dig(0, 5'b01111) | dig(1, 5'b00011) | dig(2, 5'b11110) |
                dig(3, 5'b00111) | dig(4, 5'b11111) | dig(6, 5'b11100) |
                dig(8, 5'b10000) | dig(9, 5'b00001) | dig(10, 5'b11000);

        // All zeros: only index 0 survives blanking
        add(1, '0, 0,  7'h3F, 1'b0, 0);
        add(0, '0, 3,  7'h3F, 1'b1, 1);
        add(0, '0, 6,  7'h3F, 1'b1, 1);
        add(0, '0, 9,  7'h3F, 1'b1, 1);
        add(0, '0, 11, 7'h3F, 1'b0, 1);
        // 93: ones=3, tens=9
        add(1, pat_b, 0,  7'h4F, 1'b0, 0);
        add(0, pat_b, 1,  7'h6F, 1'b0, 0);
        add(0, pat_b, 2,  7'h3F, 1'b0, 1);
        add(0, pat_b, 3,  7'h3F, 1'b1, 1);
        add(0, pat_b, 11, 7'h3F, 1'b0, 1);
        // Every digit value across the indices, leading digit at index 10
        add(1, pat_c, 0,  7'h66, 1'b0, 0);
        add(0, pat_c, 1,  7'h5B, 1'b0, 0);
        add(0, pat_c, 2,  7'h7D, 1'b0, 0);
        add(0, pat_c, 3,  7'h4F, 1'b1, 0);
        add(0, pat_c, 4,  7'h6D, 1'b0, 0);
        add(0, pat_c, 5,  7'h3F, 1'b0, 0);
        add(0, pat_c, 6,  7'h07, 1'b1, 0);
        add(0, pat_c, 7,  7'h3F, 1'b0, 0);
        add(0, pat_c, 8,  7'h6F, 1'b0, 0);
        add(0, pat_c, 9,  7'h06, 1'b1, 0);
        add(0, pat_c, 10, 7'h7F, 1'b0, 0);
        add(0, pat_c, 11, 7'h3F, 1'b0, 1);

        // ---- Reset state and first edge ----
        #23;
        chk_reset_outputs("reset");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("first_seg",   32'(SEG),     32'h3F);
        chk("first_idx",   32'(DIG_IDX), 32'd0);
        chk("first_frame", 32'(FRAME),   32'd1);
        chk("first_dp",    32'(DP),      32'd0);

        // Dwell length of the first digit
        cnt = 0;
        do begin
            cnt++;
            @(negedge CLK);
        end while (DIG_IDX == 4'd0 && cnt < 20);
        chk("dwell_len", 32'(cnt), 32'd4);
        chk("frame_pulse_width", 32'(FRAME), 32'd0);

        // Frame period
        wait_frame();
        cnt = 0;
        do begin
            @(negedge CLK);
            cnt++;
        end while (!FRAME && cnt < 200);
        chk("frame_period", 32'(cnt), 32'd48);

        // ---- Table-driven display patterns ----
        foreach (vecs[k]) begin
            if (vecs[k].load) begin
                DIGITS = vecs[k].digits;
                wait_frame();
            end
            wait_idx(vecs[k].idx);
            chk($sformatf("vec%0d_seg", k), 32'(SEG),
                32'((c_LZB && vecs[k].blank) ? 7'h00 : vecs[k].seg));
            chk($sformatf("vec%0d_dp", k), 32'(DP),
                32'((c_LZB && vecs[k].blank) ? 1'b0 : vecs[k].dp));
        end

        // ---- Invalid thousands digit and sticky ERR ----
        chk("err_clean", 32'(ERR), 32'd0);
        DIGITS = dig(3, 5'b10101);
        wait_frame();
        wait_idx(2);
        chk("err_before", 32'(ERR), 32'd0);
        wait_idx(3);
        chk("err_seg", 32'(SEG), 32'h79);
        chk("err_dp",  32'(DP),  32'd1);
        chk("err_set", 32'(ERR), 32'd1);
        wait_idx(5);
        chk("err_sticky", 32'(ERR), 32'd1);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        chk("err_cleared", 32'(ERR), 32'd0);
        wait_idx(8);
        chk("err_stays_clear", 32'(ERR), 32'd0);
        wait_frame();
        wait_idx(3);
        chk("err_reset_on_revisit", 32'(ERR), 32'd1);
        wait_idx(5);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;

        // ---- HOLD across a frame boundary ----
        DIGITS = pat_b;
        wait_frame();
        HOLD = 1'b1;
        DIGITS = dig(0, 5'b11111);
        wait_frame();
        chk("hold_old_ones", 32'(SEG), 32'h4F);
        wait_idx(1);
        chk("hold_old_tens", 32'(SEG), 32'h6F);
        wait_idx(5);
        HOLD = 1'b0;
        wait_frame();
        chk("hold_release_ones", 32'(SEG), 32'h6D);
        wait_idx(1);
        chk("hold_release_tens", 32'(SEG), c_LZB ? 32'h00 : 32'h3F);

        // ---- Asynchronous reset mid-frame ----
        DIGITS = dig(0, 5'b11100);
        wait_frame();
        wait_idx(7);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("restart_frame", 32'(FRAME),   32'd1);
        chk("restart_idx",   32'(DIG_IDX), 32'd0);
        chk("restart_seg",   32'(SEG),     32'h07);
        chk("restart_err",   32'(ERR),     32'd0);
        @(negedge CLK);
        chk("restart_frame_drop", 32'(FRAME), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
